// File: rtl/sd_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_engine
//  Description : Byte-level SPI mode-0 master driving the SD card pins, with
//                selectable slow/fast SCK divider. Optional receive CRC-16
//                (XMODEM) enabled by the SD_SPI_CRC16_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_engine #(
    parameter int SLOW_DIV = 64,
    parameter int FAST_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_cs_i,
    input  logic       cmd_fast_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       busy_o,
    output logic       sd_sck_o,
    output logic       sd_mosi_o,
    input  logic       sd_miso_i,
    output logic       sd_ss_n_o
`ifdef SD_SPI_CRC16_EN
    ,
    input  logic        crc_clr_i,
    output logic [15:0] crc16_o
`endif
);

    localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [CW-1:0] c_slow_m1 = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] c_fast_m1 = CW'(FAST_DIV - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div_m1;
    logic [3:0]    r_edge;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_sck;
    logic          r_ss_n;
    logic [7:0]    r_rsp_data;
    logic          w_tick;
    logic [CW-1:0] w_div_sel;

    assign w_tick    = (r_cnt == '0);
    assign w_div_sel = cmd_fast_i ? c_fast_m1 : c_slow_m1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (cmd_valid_i) w_state_nxt = c_st_shift;
            c_st_shift: if (w_tick && (r_edge == 4'd15)) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_div_m1   <= '0;
            r_edge     <= 4'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_sck      <= 1'b0;
            r_ss_n     <= 1'b1;
            r_rsp_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid_i) begin
                        r_tx     <= cmd_data_i;
                        r_div_m1 <= w_div_sel;
                        r_cnt    <= w_div_sel;
                        r_edge   <= 4'd0;
                        r_ss_n   <= ~cmd_cs_i;
                    end
                end
                c_st_shift: begin
                    if (w_tick) begin
                        r_cnt  <= r_div_m1;
                        r_sck  <= ~r_sck;
                        r_edge <= r_edge + 4'd1;
                        if (!r_sck) begin
                            r_rx <= {r_rx[6:0], sd_miso_i};
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                        // Last toggle is a falling edge; all 8 bits are in r_rx.
                        if (r_edge == 4'd15) r_rsp_data <= r_rx;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == c_st_idle);
    assign busy_o      = (r_state != c_st_idle);
    assign rsp_valid_o = (r_state == c_st_done);
    assign rsp_data_o  = r_rsp_data;
    assign sd_sck_o    = r_sck;
    assign sd_mosi_o   = (r_state == c_st_shift) ? r_tx[7] : 1'b1;
    assign sd_ss_n_o   = r_ss_n;

`ifdef SD_SPI_CRC16_EN
    logic [15:0] r_crc;

    function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // A clear coinciding with DONE restarts the CRC from this byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_crc <= 16'h0000;
        end else if (r_state == c_st_done) begin
            r_crc <= f_crc16(crc_clr_i ? 16'h0000 : r_crc, r_rsp_data);
        end else if (crc_clr_i) begin
            r_crc <= 16'h0000;
        end
    end

    assign crc16_o = r_crc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_engine
//  Description : Self-checking bench for sd_spi_engine with an SD-card-side
//                SPI slave model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_engine;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i = 8'h00;
    logic       cmd_cs_i = 1'b0;
    logic       cmd_fast_i = 1'b0;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       busy_o;
    logic       sd_sck_o;
    logic       sd_mosi_o;
    logic       sd_miso_i;
    logic       sd_ss_n_o;
`ifdef SD_SPI_CRC16_EN
    logic        crc_clr_i = 1'b0;
    logic [15:0] crc16_o;
    logic        xfer_clr = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    sd_spi_engine #(.SLOW_DIV(4), .FAST_DIV(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_data_i  (cmd_data_i),
        .cmd_cs_i    (cmd_cs_i),
        .cmd_fast_i  (cmd_fast_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .sd_sck_o    (sd_sck_o),
        .sd_mosi_o   (sd_mosi_o),
        .sd_miso_i   (sd_miso_i),
        .sd_ss_n_o   (sd_ss_n_o)
`ifdef SD_SPI_CRC16_EN
        ,
        .crc_clr_i   (crc_clr_i),
        .crc16_o     (crc16_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Card model: presents slv_byte MSB-first, advancing on each falling SCK.
    logic [7:0] slv_byte = 8'hFF;
    logic [2:0] slv_idx  = 3'd7;
    logic       loopback = 1'b0;
    assign sd_miso_i = loopback ? sd_mosi_o : slv_byte[slv_idx];

    int   rise_cnt = 0;
    int   rise_ss_hi = 0;
    int   rsp_cnt = 0;
    int   sck_chg = 0;
    logic prev_sck = 1'b0;
    logic mosi_q[$];

    always @(negedge clk_i) begin
        if (sd_sck_o !== prev_sck) sck_chg++;
        if (!prev_sck && sd_sck_o) begin
            rise_cnt++;
            mosi_q.push_back(sd_mosi_o);
            if (sd_ss_n_o) rise_ss_hi++;
        end
        if (prev_sck && !sd_sck_o) slv_idx = slv_idx - 3'd1;
        if (rsp_valid_o) rsp_cnt++;
        prev_sck = sd_sck_o;
    end

    task automatic step;
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic do_xfer(input logic [7:0] d, input logic cs, input logic fast,
                           input logic [7:0] mb, output logic [7:0] rsp, output int lat,
                           output logic first_ss, output logic first_busy,
                           output logic ready_after, output logic valid_after);
        slv_byte = mb;
        slv_idx  = 3'd7;
        mosi_q.delete();
        cmd_data_i  = d;
        cmd_cs_i    = cs;
        cmd_fast_i  = fast;
        cmd_valid_i = 1'b1;
        step;
        cmd_valid_i = 1'b0;
        first_ss   = sd_ss_n_o;
        first_busy = busy_o && !cmd_ready_o;
        lat = 1;
        while (!rsp_valid_o && lat < 3000) begin
            step;
            lat++;
        end
        if (!rsp_valid_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout: no rsp_valid_o after %0d cycles", lat);
        end
        rsp = rsp_data_o;
`ifdef SD_SPI_CRC16_EN
        crc_clr_i = xfer_clr;
`endif
        step;
        ready_after = cmd_ready_o;
        valid_after = rsp_valid_o;
`ifdef SD_SPI_CRC16_EN
        crc_clr_i = 1'b0;
`endif
    endtask

    task automatic test_reset;
        int base_chg;
        rst_i = 1'b1;
        step;
        step;
        rst_i = 1'b0;
        n_cmp++; if (sd_sck_o !== 1'b0) begin n_bad++; $display("FAIL rst_sck: got %b want 0", sd_sck_o); end
        n_cmp++; if (sd_mosi_o !== 1'b1) begin n_bad++; $display("FAIL rst_mosi: got %b want 1", sd_mosi_o); end
        n_cmp++; if (sd_ss_n_o !== 1'b1) begin n_bad++; $display("FAIL rst_ss_n: got %b want 1", sd_ss_n_o); end
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data_o); end
`ifdef SD_SPI_CRC16_EN
        n_cmp++; if (crc16_o !== 16'h0000) begin n_bad++; $display("FAIL rst_crc: got %h want 0000", crc16_o); end
`endif
        base_chg = sck_chg;
        repeat (100) step;
        n_cmp++; if (sck_chg != base_chg) begin n_bad++; $display("FAIL idle_sck_toggles: got %0d want 0", sck_chg - base_chg); end
        n_cmp++; if (sd_sck_o !== 1'b0) begin n_bad++; $display("FAIL idle_sck: got %b want 0", sd_sck_o); end
    endtask

    task automatic test_slow_byte;
        logic [7:0] d, mb, rsp, mo;
        logic       fast, fss, fbusy, rdy, vld;
        int         lat, ss_base;
        for (int it = 0; it < 6; it++) begin
            d    = (it == 0) ? 8'hA5 : 8'($urandom);
            mb   = (it == 0) ? 8'h3C : 8'($urandom);
            fast = (it == 0) ? 1'b0 : 1'($urandom);
            ss_base = rise_ss_hi;
            do_xfer(d, 1'b1, fast, mb, rsp, lat, fss, fbusy, rdy, vld);
            mo = 8'h00;
            foreach (mosi_q[i]) mo = {mo[6:0], mosi_q[i]};
            n_cmp++; if (rsp !== mb) begin n_bad++; $display("FAIL byte_rsp[%0d]: got %h want %h", it, rsp, mb); end
            n_cmp++; if (lat != 16 * (fast ? 1 : 4) + 1) begin n_bad++; $display("FAIL byte_latency[%0d]: got %0d want %0d", it, lat, 16 * (fast ? 1 : 4) + 1); end
            n_cmp++; if (mosi_q.size() != 8 || mo !== d) begin n_bad++; $display("FAIL byte_mosi[%0d]: got %h (%0d bits) want %h", it, mo, mosi_q.size(), d); end
            n_cmp++; if (rise_ss_hi != ss_base || fss !== 1'b0) begin n_bad++; $display("FAIL byte_cs[%0d]: got %0d rises with ss_n high want 0", it, rise_ss_hi - ss_base); end
            n_cmp++; if (fbusy !== 1'b1) begin n_bad++; $display("FAIL byte_busy[%0d]: got %b want 1", it, fbusy); end
            n_cmp++; if (rdy !== 1'b1 || vld !== 1'b0) begin n_bad++; $display("FAIL byte_post[%0d]: got ready=%b valid=%b want 1/0", it, rdy, vld); end
            n_cmp++; if (rsp_data_o !== mb) begin n_bad++; $display("FAIL byte_hold[%0d]: got %h want %h", it, rsp_data_o, mb); end
        end
    endtask

    task automatic test_init_clocks;
        logic [7:0] rsp;
        logic       fss, fbusy, rdy, vld;
        int         lat, r0, h0;
        r0 = rise_cnt;
        h0 = rise_ss_hi;
        for (int i = 0; i < 10; i++) do_xfer(8'hFF, 1'b0, 1'b0, 8'hFF, rsp, lat, fss, fbusy, rdy, vld);
        n_cmp++; if (rise_cnt - r0 != 80) begin n_bad++; $display("FAIL init_rises: got %0d want 80", rise_cnt - r0); end
        n_cmp++; if (rise_ss_hi - h0 != 80) begin n_bad++; $display("FAIL init_ss_high: got %0d want 80", rise_ss_hi - h0); end
        n_cmp++; if (sd_ss_n_o !== 1'b1) begin n_bad++; $display("FAIL init_ss_idle: got %b want 1", sd_ss_n_o); end
        do_xfer(8'h40, 1'b1, 1'b0, 8'h01, rsp, lat, fss, fbusy, rdy, vld);
        n_cmp++; if (fss !== 1'b0) begin n_bad++; $display("FAIL init_cs_fall: got %b want 0", fss); end
        n_cmp++; if (rsp !== 8'h01) begin n_bad++; $display("FAIL init_rsp: got %h want 01", rsp); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b[4];
        int         hs[4];
        int         k, r, cyc, bad_ss;
        foreach (b[i]) b[i] = 8'($urandom);
        loopback = 1'b1;
        k = 0; r = 0; cyc = 0; bad_ss = 0;
        cmd_cs_i = 1'b1;
        cmd_fast_i = 1'b1;
        while (r < 4 && cyc < 400) begin
            if (rsp_valid_o) begin
                n_cmp++; if (rsp_data_o !== b[r]) begin n_bad++; $display("FAIL b2b_echo[%0d]: got %h want %h", r, rsp_data_o, b[r]); end
                r++;
            end
            if (cmd_ready_o) begin
                if (k < 4) begin
                    cmd_valid_i = 1'b1;
                    cmd_data_i  = b[k];
                    hs[k] = cyc;
                    k++;
                end else begin
                    cmd_valid_i = 1'b0;
                end
            end
            if (sd_ss_n_o !== 1'b0) bad_ss++;
            if (r < 4) begin
                step;
                cyc++;
            end
        end
        cmd_valid_i = 1'b0;
        loopback = 1'b0;
        n_cmp++; if (r != 4) begin n_bad++; $display("FAIL b2b_count: got %0d responses want 4", r); end
        for (int i = 1; i < k; i++) begin
            n_cmp++; if (hs[i] - hs[i-1] != 18) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 18", i, hs[i] - hs[i-1]); end
        end
        n_cmp++; if (bad_ss != 0) begin n_bad++; $display("FAIL b2b_cs: got %0d cycles with ss_n high want 0", bad_ss); end
        step;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d, mb, rsp;
        logic       fss, fbusy, rdy, vld;
        int         lat, c0, p0, t;
        slv_byte = 8'h5A;
        slv_idx  = 3'd7;
        cmd_data_i  = 8'hC3;
        cmd_cs_i    = 1'b1;
        cmd_fast_i  = 1'b0;
        cmd_valid_i = 1'b1;
        c0 = sck_chg;
        step;
        cmd_valid_i = 1'b0;
        t = 0;
        while (sck_chg - c0 < 3 && t < 200) begin
            step;
            t++;
        end
        p0 = rsp_cnt;
        rst_i = 1'b1;
        step;
        n_cmp++; if (sd_sck_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sck: got %b want 0", sd_sck_o); end
        n_cmp++; if (sd_ss_n_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ss_n: got %b want 1", sd_ss_n_o); end
        n_cmp++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_state: got ready=%b busy=%b want 1/0", cmd_ready_o, busy_o); end
        n_cmp++; if (sd_mosi_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_mosi: got %b want 1", sd_mosi_o); end
        rst_i = 1'b0;
        repeat (80) step;
        n_cmp++; if (rsp_cnt != p0) begin n_bad++; $display("FAIL mid_rst_no_rsp: got %0d pulses want 0", rsp_cnt - p0); end
        n_cmp++; if (rsp_data_o !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rsp_data: got %h want 00", rsp_data_o); end
        d  = 8'($urandom);
        mb = 8'($urandom);
        do_xfer(d, 1'b1, 1'b0, mb, rsp, lat, fss, fbusy, rdy, vld);
        n_cmp++; if (rsp !== mb || lat != 65) begin n_bad++; $display("FAIL mid_rst_recover: got %h lat %0d want %h lat 65", rsp, lat, mb); end
    endtask

`ifdef SD_SPI_CRC16_EN
    task automatic test_crc;
        logic [7:0]  msg[9];
        logic [7:0]  rsp, mb;
        logic        fss, fbusy, rdy, vld;
        logic [15:0] exp_crc;
        int          lat;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        crc_clr_i = 1'b1;
        step;
        crc_clr_i = 1'b0;
        n_cmp++; if (crc16_o !== 16'h0000) begin n_bad++; $display("FAIL crc_clear: got %h want 0000", crc16_o); end
        foreach (msg[i]) do_xfer(8'($urandom), 1'b1, 1'b1, msg[i], rsp, lat, fss, fbusy, rdy, vld);
        n_cmp++; if (crc16_o !== 16'h31C3) begin n_bad++; $display("FAIL crc_check_string: got %h want 31c3", crc16_o); end
        xfer_clr = 1'b1;
        do_xfer(8'hFF, 1'b1, 1'b1, 8'h00, rsp, lat, fss, fbusy, rdy, vld);
        xfer_clr = 1'b0;
        n_cmp++; if (crc16_o !== 16'h0000) begin n_bad++; $display("FAIL crc_clr_done_zero: got %h want 0000", crc16_o); end
        exp_crc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            mb = 8'($urandom);
            do_xfer(8'($urandom), 1'b1, 1'b1, mb, rsp, lat, fss, fbusy, rdy, vld);
            exp_crc = crc_ref(exp_crc, mb);
        end
        n_cmp++; if (crc16_o !== exp_crc) begin n_bad++; $display("FAIL crc_random: got %h want %h", crc16_o, exp_crc); end
        mb = 8'($urandom_range(1, 255));
        xfer_clr = 1'b1;
        do_xfer(8'h00, 1'b1, 1'b1, mb, rsp, lat, fss, fbusy, rdy, vld);
        xfer_clr = 1'b0;
        n_cmp++; if (crc16_o !== crc_ref(16'h0000, mb)) begin n_bad++; $display("FAIL crc_clr_done_byte: got %h want %h", crc16_o, crc_ref(16'h0000, mb)); end
    endtask
`endif

    initial begin
        test_reset();
        test_slow_byte();
        test_init_clocks();
        test_back_to_back();
        test_reset_mid();
`ifdef SD_SPI_CRC16_EN
        test_crc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
